// File: rtl/hplvds_rx_link_ctrl.sv
// HPLVDS receive-pad link controller: power-up sequencing of the RX cell,
// DI/EI synchronisation, electrical-idle debounce and LSB-first word deserialiser.
`timescale 1ns/1ps
module hplvds_rx_link_ctrl #(
  parameter int WORD_W     = 10,
  parameter int SETTLE_CYC = 64,
  parameter int IDLE_DEB   = 8
) (
  input  logic              CLK_I,
  input  logic              RSTN_I,
  input  logic              LINK_EN_I,
  input  logic [3:0]        RTERM_TRIM_CFG_I,
  input  logic              RX_POL_CFG_I,
  input  logic              DI_I,
  input  logic              EI_DETECT_I,
  output logic              RTERM_EN_O,
  output logic [3:0]        RTERM_TRIM_O,
  output logic              RX_VCM_EN_O,
  output logic              RX_EN_O,
  output logic              RX_POL_O,
  output logic              EI_DETECT_EN_O,
  output logic              READY_O,
  output logic              IDLE_O,
  output logic [WORD_W-1:0] WORD_O,
  output logic              WORD_VLD_O,
  output logic [1:0]        STATE_O
);

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int DW = $clog2(IDLE_DEB + 1);
  localparam int BW = $clog2(WORD_W);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [DW-1:0] IDLE_MAX    = DW'(IDLE_DEB);
  localparam logic [DW-1:0] IDLE_PRE    = DW'(IDLE_DEB - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(WORD_W - 1);

  typedef enum logic [1:0] {
    OFF    = 2'd0,
    TERM   = 2'd1,
    RXON   = 2'd2,
    ACTIVE = 2'd3
  } linkState_e;

  linkState_e        state, nextState;
  logic [SW-1:0]     settleCnt, settleCntNext;

  logic              termOn;
  logic              rxOn;
  logic              ready;
  logic [3:0]        trimQ;
  logic              polQ;

  logic              diMeta, diSync;
  logic              eiMeta, eiSync;

  logic [DW-1:0]     idleCnt;
  logic              idle;

  logic [WORD_W-1:0] shiftReg;
  logic [BW-1:0]     bitCnt;
  logic [WORD_W-1:0] wordQ;
  logic              wordVld;

  // State and settle-counter register
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      state     <= OFF;
      settleCnt <= '0;
    end else begin
      state     <= nextState;
      settleCnt <= settleCntNext;
    end
  end

  // Next-state logic: link-enable drop overrides every state; each settle state
  // lasts SETTLE_CYC cycles by counting the loaded value down to zero
  always_comb begin
    nextState     = state;
    settleCntNext = settleCnt;
    if (!LINK_EN_I) begin
      nextState     = OFF;
      settleCntNext = '0;
    end else begin
      unique case (state)
        OFF: begin
          nextState     = TERM;
          settleCntNext = SETTLE_LAST;
        end
        TERM: begin
          if (settleCnt == '0) begin
            nextState     = RXON;
            settleCntNext = SETTLE_LAST;
          end else begin
            settleCntNext = settleCnt - SW'(1);
          end
        end
        RXON: begin
          if (settleCnt == '0) begin
            nextState     = ACTIVE;
            settleCntNext = '0;
          end else begin
            settleCntNext = settleCnt - SW'(1);
          end
        end
        ACTIVE: begin
          nextState     = ACTIVE;
          settleCntNext = '0;
        end
        default: begin
          nextState     = OFF;
          settleCntNext = '0;
        end
      endcase
    end
  end

  // Pad control outputs registered from the next state so they track STATE_O exactly
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      termOn <= 1'b0;
      rxOn   <= 1'b0;
      ready  <= 1'b0;
    end else begin
      termOn <= (nextState != OFF);
      rxOn   <= (nextState == RXON) || (nextState == ACTIVE);
      ready  <= (nextState == ACTIVE);
    end
  end

  // Configuration pass-through, refreshed every cycle independent of link state
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      trimQ <= '0;
      polQ  <= 1'b0;
    end else begin
      trimQ <= RTERM_TRIM_CFG_I;
      polQ  <= RX_POL_CFG_I;
    end
  end

  // Two-flop synchronisers for pad data and idle flag, held clear while powered down
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      diMeta <= 1'b0;
      diSync <= 1'b0;
      eiMeta <= 1'b0;
      eiSync <= 1'b0;
    end else if (state == OFF) begin
      diMeta <= 1'b0;
      diSync <= 1'b0;
      eiMeta <= 1'b0;
      eiSync <= 1'b0;
    end else begin
      diMeta <= DI_I;
      diSync <= diMeta;
      eiMeta <= EI_DETECT_I;
      eiSync <= eiMeta;
    end
  end

  // Idle debounce: saturating run-length of synced EI=1; IDLE_O set on the edge the run reaches IDLE_DEB
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      idleCnt <= '0;
      idle    <= 1'b0;
    end else if (!LINK_EN_I || !rxOn || !eiSync) begin
      idleCnt <= '0;
      idle    <= 1'b0;
    end else begin
      if (idleCnt != IDLE_MAX) begin
        idleCnt <= idleCnt + DW'(1);
      end
      idle <= (idleCnt >= IDLE_PRE);
    end
  end

  // Deserialiser: LSB-first shift while ready and not idle; a full word loads WORD_O with a one-cycle strobe
  always_ff @(posedge CLK_I or negedge RSTN_I) begin
    if (!RSTN_I) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      wordQ    <= '0;
      wordVld  <= 1'b0;
    end else begin
      wordVld <= 1'b0;
      if (!LINK_EN_I || !ready || idle) begin
        bitCnt <= '0;
      end else begin
        shiftReg <= {diSync, shiftReg[WORD_W-1:1]};
        if (bitCnt == BIT_LAST) begin
          wordQ   <= {diSync, shiftReg[WORD_W-1:1]};
          wordVld <= 1'b1;
          bitCnt  <= '0;
        end else begin
          bitCnt <= bitCnt + BW'(1);
        end
      end
    end
  end

  assign STATE_O        = state;
  assign RTERM_EN_O     = termOn;
  assign RX_VCM_EN_O    = termOn;
  assign RX_EN_O        = rxOn;
  assign EI_DETECT_EN_O = rxOn;
  assign READY_O        = ready;
  assign RTERM_TRIM_O   = trimQ;
  assign RX_POL_O       = polQ;
  assign IDLE_O         = idle;
  assign WORD_O         = wordQ;
  assign WORD_VLD_O     = wordVld;

endmodule

// File: tb/tb_hplvds_rx_link_ctrl.sv
// Self-checking bench for hplvds_rx_link_ctrl: directed scenarios plus a random
// phase, all checked against a behavioural model kept in this file.
`timescale 1ns/1ps
module tb_hplvds_rx_link_ctrl;

  localparam int W = 10;
  localparam int S = 4;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         RSTN_I;
  logic         LINK_EN_I;
  logic [3:0]   RTERM_TRIM_CFG_I;
  logic         RX_POL_CFG_I;
  logic         DI_I;
  logic         EI_DETECT_I;
  logic         RTERM_EN_O;
  logic [3:0]   RTERM_TRIM_O;
  logic         RX_VCM_EN_O;
  logic         RX_EN_O;
  logic         RX_POL_O;
  logic         EI_DETECT_EN_O;
  logic         READY_O;
  logic         IDLE_O;
  logic [W-1:0] WORD_O;
  logic         WORD_VLD_O;
  logic [1:0]   STATE_O;

  always #5 clk = ~clk;

  hplvds_rx_link_ctrl #(.WORD_W(W), .SETTLE_CYC(S), .IDLE_DEB(D)) dut (
    .CLK_I(clk), .RSTN_I(RSTN_I), .LINK_EN_I(LINK_EN_I),
    .RTERM_TRIM_CFG_I(RTERM_TRIM_CFG_I), .RX_POL_CFG_I(RX_POL_CFG_I),
    .DI_I(DI_I), .EI_DETECT_I(EI_DETECT_I),
    .RTERM_EN_O(RTERM_EN_O), .RTERM_TRIM_O(RTERM_TRIM_O), .RX_VCM_EN_O(RX_VCM_EN_O),
    .RX_EN_O(RX_EN_O), .RX_POL_O(RX_POL_O), .EI_DETECT_EN_O(EI_DETECT_EN_O),
    .READY_O(READY_O), .IDLE_O(IDLE_O), .WORD_O(WORD_O), .WORD_VLD_O(WORD_VLD_O),
    .STATE_O(STATE_O)
  );

  int checkCnt = 0;
  int passCnt  = 0;
  int failCnt  = 0;

  // Behavioural model: link state from the length of the current LINK_EN run,
  // raw-input delay line for the synchronisers, idle run length, bit queue for words.
  int           mLinkCyc;
  bit           mDi1, mDi2, mEi1, mEi2;
  int           mEiRun;
  bit           mBits[$];
  logic [W-1:0] mWord;
  bit           mVld;
  logic [3:0]   mTrim;
  bit           mPol;

  function automatic int stateOf(input int c);
    if (c == 0) return 0;
    if (c <= S) return 1;
    if (c <= 2 * S) return 2;
    return 3;
  endfunction

  task automatic modelReset();
    mLinkCyc = 0;
    mDi1 = 0; mDi2 = 0; mEi1 = 0; mEi2 = 0;
    mEiRun = 0;
    mBits.delete();
    mWord = '0;
    mVld = 0;
    mTrim = '0;
    mPol = 0;
  endtask

  task automatic modelEdge();
    int preState;
    bit preIdle, preDi, preEi;
    if (!RSTN_I) begin
      modelReset();
      return;
    end
    preState = stateOf(mLinkCyc);
    preIdle  = (mEiRun >= D);
    preDi    = mDi2;
    preEi    = mEi2;
    mLinkCyc = LINK_EN_I ? ((mLinkCyc < 1000) ? mLinkCyc + 1 : mLinkCyc) : 0;
    if (preState == 0) begin
      mDi1 = 0; mDi2 = 0; mEi1 = 0; mEi2 = 0;
    end else begin
      mDi2 = mDi1; mDi1 = DI_I;
      mEi2 = mEi1; mEi1 = EI_DETECT_I;
    end
    if (!LINK_EN_I || preState < 2 || !preEi) mEiRun = 0;
    else if (mEiRun < D) mEiRun++;
    mVld = 0;
    if (LINK_EN_I && preState == 3 && !preIdle) begin
      mBits.push_back(preDi);
      if (mBits.size() == W) begin
        for (int i = 0; i < W; i++) mWord[i] = mBits[i];
        mVld = 1;
        mBits.delete();
      end
    end else begin
      mBits.delete();
    end
    mTrim = RTERM_TRIM_CFG_I;
    mPol  = RX_POL_CFG_I;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    assert (obs === exp) passCnt++;
    else begin
      failCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    int st;
    st = stateOf(mLinkCyc);
    check("state", 32'(STATE_O), 32'(st));
    check("rterm_en", 32'(RTERM_EN_O), 32'(st >= 1));
    check("vcm_en", 32'(RX_VCM_EN_O), 32'(st >= 1));
    check("rx_en", 32'(RX_EN_O), 32'(st >= 2));
    check("ei_det_en", 32'(EI_DETECT_EN_O), 32'(st >= 2));
    check("ready", 32'(READY_O), 32'(st == 3));
    check("idle", 32'(IDLE_O), 32'(mEiRun >= D));
    check("word_vld", 32'(WORD_VLD_O), 32'(mVld));
    check("word", 32'(WORD_O), 32'(mWord));
    check("trim", 32'(RTERM_TRIM_O), 32'(mTrim));
    check("pol", 32'(RX_POL_O), 32'(mPol));
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_state"}, 32'(STATE_O), 0);
    check({tag, "_rterm"}, 32'(RTERM_EN_O), 0);
    check({tag, "_vcm"}, 32'(RX_VCM_EN_O), 0);
    check({tag, "_rxen"}, 32'(RX_EN_O), 0);
    check({tag, "_eien"}, 32'(EI_DETECT_EN_O), 0);
    check({tag, "_ready"}, 32'(READY_O), 0);
    check({tag, "_idle"}, 32'(IDLE_O), 0);
    check({tag, "_vld"}, 32'(WORD_VLD_O), 0);
    check({tag, "_word"}, 32'(WORD_O), 0);
    check({tag, "_trim"}, 32'(RTERM_TRIM_O), 0);
    check({tag, "_pol"}, 32'(RX_POL_O), 0);
  endtask

  // One clock: model advances on the rising edge, DUT compared on the falling edge,
  // then config inputs are re-randomised.
  task automatic step();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
    RTERM_TRIM_CFG_I = 4'($urandom_range(0, 15));
    RX_POL_CFG_I     = 1'($urandom_range(0, 1));
  endtask

  // Bring-up from OFF with LINK_EN just raised (edge 0 = the next step's preceding edge),
  // then one word whose first bit is driven after edge 7 so it is the first bit shifted in ACTIVE.
  task automatic bringUp(input string tag, input logic [W-1:0] w);
    int vldCnt;
    vldCnt = 0;
    DI_I = 0;
    EI_DETECT_I = 0;
    for (int i = 1; i <= 22; i++) begin
      step();
      if (WORD_VLD_O === 1'b1) vldCnt++;
      if (i == 1) check({tag, "_state@1"}, 32'(STATE_O), 1);
      if (i == 4) begin
        check({tag, "_state@4"}, 32'(STATE_O), 1);
        check({tag, "_rxen@4"}, 32'(RX_EN_O), 0);
      end
      if (i == 5) begin
        check({tag, "_state@5"}, 32'(STATE_O), 2);
        check({tag, "_rxen@5"}, 32'(RX_EN_O), 1);
      end
      if (i == 8) check({tag, "_ready@8"}, 32'(READY_O), 0);
      if (i == 9) begin
        check({tag, "_state@9"}, 32'(STATE_O), 3);
        check({tag, "_ready@9"}, 32'(READY_O), 1);
      end
      if (i == 19) begin
        check({tag, "_vld@19"}, 32'(WORD_VLD_O), 1);
        check({tag, "_word@19"}, 32'(WORD_O), 32'(w));
      end
      DI_I = (i >= 7 && i <= 16) ? w[i-7] : 1'b0;
    end
    check({tag, "_vld_count"}, 32'(vldCnt), 1);
  endtask

  task automatic idleTrial(input string tag, input int n, input bit expSaw);
    bit saw;
    saw = 0;
    EI_DETECT_I = 1;
    for (int i = 0; i < n + 14; i++) begin
      if (i == n) EI_DETECT_I = 0;
      step();
      if (IDLE_O === 1'b1) saw = 1;
    end
    check(tag, 32'(saw), 32'(expSaw));
  endtask

  task automatic forceIdle();
    EI_DETECT_I = 1;
    repeat (12) step();
    EI_DETECT_I = 0;
  endtask

  initial begin
    logic [W-1:0] w155;
    logic [5:0]   part;
    logic [W-1:0] wDrop;
    int           vldCnt;
    w155  = 10'h155;
    part  = 6'b101101;
    wDrop = W'($urandom_range(0, 1023));

    RSTN_I = 0; LINK_EN_I = 0; DI_I = 0; EI_DETECT_I = 0;
    RTERM_TRIM_CFG_I = 4'hA; RX_POL_CFG_I = 1;
    modelReset();
    #1;
    checkZero("reset");
    repeat (2) step();

    // Scenarios 1+2: bring-up timing and first word 10'h2A5
    RSTN_I = 1;
    LINK_EN_I = 1;
    bringUp("bringup", 10'h2A5);

    // Scenario 3: idle debounce threshold
    idleTrial("idle_7_synced", 7, 1'b0);
    idleTrial("idle_8_synced", 8, 1'b1);

    // Scenario 4: partial word discarded by idle, then 10'h155 reported alone
    forceIdle();
    vldCnt = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if (WORD_VLD_O === 1'b1) vldCnt++;
      if (k == 28) begin
        check("resume_vld", 32'(WORD_VLD_O), 1);
        check("resume_word", 32'(WORD_O), 32'(w155));
      end
      if (k < 6) DI_I = part[k];
      else if (k >= 16 && k < 26) DI_I = w155[k-16];
      else DI_I = 0;
      EI_DETECT_I = (k >= 1 && k < 15);
    end
    check("resume_vld_count", 32'(vldCnt), 1);

    // Scenario 5: LINK_EN drop on the 10th-bit edge suppresses the strobe
    forceIdle();
    vldCnt = 0;
    for (int k = 0; k <= 12; k++) begin
      step();
      if (WORD_VLD_O === 1'b1) vldCnt++;
      DI_I = (k < 10) ? wDrop[k] : 1'b0;
      if (k == 11) LINK_EN_I = 0;
    end
    check("drop_vld_count", 32'(vldCnt), 0);
    check("drop_state", 32'(STATE_O), 0);
    check("drop_rterm", 32'(RTERM_EN_O), 0);
    check("drop_vcm", 32'(RX_VCM_EN_O), 0);
    check("drop_rxen", 32'(RX_EN_O), 0);
    check("drop_eien", 32'(EI_DETECT_EN_O), 0);
    check("drop_ready", 32'(READY_O), 0);
    repeat (3) step();

    // Scenario 6: asynchronous reset mid-word, then identical re-bring-up
    LINK_EN_I = 1;
    repeat (14) step();
    for (int k = 0; k < 5; k++) begin
      DI_I = 1'($urandom_range(0, 1));
      step();
    end
    #2;
    RSTN_I = 0;
    #1;
    checkZero("async_rst");
    step();
    RSTN_I = 1;
    bringUp("rebringup", 10'h0F3);

    // Random phase: random data, idle bursts, occasional link drops
    for (int k = 0; k < 700; k++) begin
      DI_I = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) EI_DETECT_I = ~EI_DETECT_I;
      if ($urandom_range(0, 149) == 0) LINK_EN_I = ~LINK_EN_I;
      step();
    end

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
